rv16_boot_ctrl: RTL and testbench

Boot/program-load controller for the rv16r core. It holds the core in reset, streams 16-bit instruction words from a valid/ready source into the 1024-word instruction RAM at sequential addresses, then releases the core after a fixed reset-hold delay. It replaces `$readmemh` preloading and makes the same load path usable from a UART/debug bridge and from the testbench.

---
 rtl/rv16_pkg.sv | 19 +
 rtl/rv16_boot_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rv16_boot_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv16_pkg.sv
// Shared rv16 definitions: instruction memory geometry, word width and the
// boot controller state encoding.
package rv16_pkg;

    localparam int RV16_IMEM_DEPTH    = 1024;
    localparam int RV16_IMEM_ADDR_W   = 10;
    localparam int RV16_WORD_W        = 16;
    localparam int RV16_BOOT_RST_HOLD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } boot_state_t;

endpackage

// File: rtl/rv16_boot_ctrl.sv
// rv16_boot_ctrl: holds the rv16r core in reset, streams instruction words
// from a valid/ready source into the instruction RAM at sequential addresses,
// then releases the core after a fixed reset-hold delay.
//
// Optional feature macro: RV16_BOOT_CHECKSUM_EN
//   defined   -> one trailing word after the image is compared with the
//                16-bit wrap-around sum of the image; a mismatch ends in ERROR.
//   undefined -> no checksum word, no accumulator; LOAD goes straight to HOLD.
module rv16_boot_ctrl
    import rv16_pkg::*;
#(
    parameter int ADDR_W   = RV16_IMEM_ADDR_W,
    parameter int DEPTH    = RV16_IMEM_DEPTH,
    parameter int RST_HOLD = RV16_BOOT_RST_HOLD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W:0]        len,
    input  logic                   in_valid,
    input  logic [RV16_WORD_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [RV16_WORD_W-1:0] mem_wdata,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    // Width of the reset-hold down-counter; the +2 keeps it at least one bit
    // wide even for a zero hold.
    localparam int                 HOLD_W    = $clog2(RST_HOLD + 2);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RST_HOLD);
    localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    // State that follows the last image word (or an empty image).
`ifdef RV16_BOOT_CHECKSUM_EN
    localparam boot_state_t POST_LOAD = CHECK;
`else
    localparam boot_state_t POST_LOAD = HOLD;
`endif

    boot_state_t            state_q, state_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   in_ready_q, in_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [RV16_WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                   core_rst_q, core_rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   handshake;
`ifdef RV16_BOOT_CHECKSUM_EN
    logic [RV16_WORD_W-1:0] acc_q, acc_d;
`endif

    // Next-state and next-output logic; every output is derived from the
    // next state so that all ports come straight from flops.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef RV16_BOOT_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        handshake   = in_valid && in_ready_q;

        case (state_q)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    cnt_d = '0;
`ifdef RV16_BOOT_CHECKSUM_EN
                    acc_d = '0;
`endif
                    if (len > DEPTH_L) begin
                        state_d = ERROR;
                    end else if (len == '0) begin
                        state_d = POST_LOAD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = LOAD;
                        len_d   = len;
                    end
                end
            end
            LOAD: begin
                if (handshake) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    cnt_d       = cnt_q + 1'b1;
`ifdef RV16_BOOT_CHECKSUM_EN
                    acc_d       = acc_q + in_data;
`endif
                    if ((cnt_q + 1'b1) == len_q) begin
                        state_d = POST_LOAD;
                        hold_d  = HOLD_INIT;
                    end
                end
            end
`ifdef RV16_BOOT_CHECKSUM_EN
            CHECK: begin
                if (handshake) begin
                    if (in_data == acc_q) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
`endif
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // in_ready is high throughout LOAD; in CHECK it rises one cycle after
        // entry and falls again once the checksum word is taken.
        in_ready_d = (state_d == LOAD)
`ifdef RV16_BOOT_CHECKSUM_EN
                   || ((state_q == CHECK) && (state_d == CHECK))
`endif
                   ;
        core_rst_d = (state_d != RUN);
        busy_d     = (state_d == LOAD) || (state_d == CHECK) || (state_d == HOLD);
        done_d     = (state_d == RUN) && (state_q != RUN);
        err_d      = (state_d == ERROR);
    end

    // State register and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef RV16_BOOT_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef RV16_BOOT_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rv16_boot_ctrl.sv
// Testbench for rv16_boot_ctrl. Stimulus pushes the expected RAM writes and
// expected done cycles into queues; a monitor process pops and compares them
// whenever the block strobes mem_we or pulses done.
// Honours RV16_BOOT_CHECKSUM_EN the same way the design does.
module tb_rv16_boot_ctrl;

    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1024;
    localparam int RST_HOLD = 4;

    // With the checksum present the release is two cycles later: one cycle of
    // in_ready low after the last image word, then the checksum handshake.
`ifdef RV16_BOOT_CHECKSUM_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    wr_t         wr_q[$];
    int          done_q[$];
    logic [15:0] src_q[$];
    wr_t         mon_e;
    int          mon_exp;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    int          cs;
    logic [15:0] sum;

    rv16_boot_ctrl #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Release cycle for an N-word image when the source never stalls,
    // counted from the cycle in which start is high.
    function automatic int exp_done(input int cstart, input int n);
        return cstart + n + RST_HOLD + 2 + TAIL;
    endfunction

    // Pulse start for one cycle; called and returns on a falling edge.
    task automatic start_load(input int n, output int cstart);
        start  = 1'b1;
        len    = (ADDR_W + 1)'(n);
        cstart = cyc;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Feed src_q to the source port; the first nwr words are image words
    // that must appear as RAM writes. Optionally stall every other cycle.
    task automatic applyStimulus(input int nwr, input bit stall);
        int  idx    = 0;
        int  budget = 0;
        bit  phase  = 1'b0;
        wr_t e;
        while (idx < src_q.size() && budget < 4000) begin
            phase    = stall ? ~phase : 1'b1;
            in_valid = phase;
            in_data  = src_q[idx];
            if (phase && in_ready) begin
                if (idx < nwr) begin
                    e.addr = idx[ADDR_W-1:0];
                    e.data = src_q[idx];
                    wr_q.push_back(e);
                end
                idx++;
            end
            budget++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("source_words_taken", idx, src_q.size());
        src_q.delete();
    endtask

    // Wait (bounded) for done or err to go high.
    task automatic wait_for(input string name, input bit want_err);
        int n = 0;
        while (((want_err ? err : done) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("[TB] FAIL %s timeout actual=none required=pulse", name);
        end
    endtask

    // Scoreboard monitor: every RAM write and every done pulse must match
    // the next expectation queued by the stimulus.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual addr=%0d data=%h required none", mem_addr, mem_wdata);
            end else begin
                mon_e = wr_q.pop_front();
                checkOutput("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                checkOutput("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_exp = done_q.pop_front();
                if (mon_exp >= 0) checkOutput("done_cycle", cyc, mon_exp);
                checkOutput("done_core_rst", 32'(core_rst), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset release: core held, nothing busy, no writes.
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_core_rst", 32'(core_rst), 1);
            checkOutput("reset_busy", 32'(busy), 0);
            checkOutput("reset_err", 32'(err), 0);
            checkOutput("reset_mem_we", 32'(mem_we), 0);
            checkOutput("reset_in_ready", 32'(in_ready), 0);
            checkOutput("reset_done", 32'(done), 0);
            checkOutput("reset_mem_addr", 32'(mem_addr), 0);
        end

        // Basic three-word load, source never stalls.
        start_load(3, cs);
        checkOutput("basic_busy", 32'(busy), 1);
        checkOutput("basic_core_rst", 32'(core_rst), 1);
        done_q.push_back(exp_done(cs, 3));
        src_q = '{16'h1111, 16'h2222, 16'h3333};
`ifdef RV16_BOOT_CHECKSUM_EN
        src_q.push_back(16'h6666);
`endif
        applyStimulus(3, 1'b0);
        wait_for("basic_run", 1'b0);
        @(negedge clk);
        checkOutput("basic_done_pulse", 32'(done), 0);
        checkOutput("basic_run_core_rst", 32'(core_rst), 0);
        checkOutput("basic_run_busy", 32'(busy), 0);

        // Four words with the source stalling every other cycle.
        start_load(4, cs);
        done_q.push_back(-1);
        src_q = '{16'hA001, 16'h0B02, 16'h00C3, 16'h1004};
`ifdef RV16_BOOT_CHECKSUM_EN
        src_q.push_back(16'hBBCA);
`endif
        applyStimulus(4, 1'b1);
        wait_for("stall_run", 1'b0);
        @(negedge clk);

        // Empty image goes straight to the hold phase.
        start_load(0, cs);
        checkOutput("empty_busy", 32'(busy), 1);
        done_q.push_back(exp_done(cs, 0));
`ifdef RV16_BOOT_CHECKSUM_EN
        src_q = '{16'h0000};
        applyStimulus(0, 1'b0);
`endif
        wait_for("empty_run", 1'b0);
        @(negedge clk);

        // Largest legal image: last write lands at DEPTH-1.
        start_load(DEPTH, cs);
        done_q.push_back(exp_done(cs, DEPTH));
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            src_q.push_back(16'(i * 37) ^ 16'h5A5A);
            sum = sum + (16'(i * 37) ^ 16'h5A5A);
        end
`ifdef RV16_BOOT_CHECKSUM_EN
        src_q.push_back(sum);
`endif
        applyStimulus(DEPTH, 1'b0);
        wait_for("full_run", 1'b0);
        @(negedge clk);

        // Oversize length from RUN: straight to ERROR, no writes.
        start_load(DEPTH + 1, cs);
        checkOutput("over_err", 32'(err), 1);
        checkOutput("over_core_rst", 32'(core_rst), 1);
        checkOutput("over_busy", 32'(busy), 0);
        checkOutput("over_in_ready", 32'(in_ready), 0);
        repeat (3) @(negedge clk);
        checkOutput("over_err_held", 32'(err), 1);
        checkOutput("over_mem_we", 32'(mem_we), 0);

`ifdef RV16_BOOT_CHECKSUM_EN
        // Good checksum from ERROR: 0xFFFF + 0x0002 wraps to 0x0001.
        start_load(2, cs);
        done_q.push_back(exp_done(cs, 2));
        src_q = '{16'hFFFF, 16'h0002, 16'h0001};
        applyStimulus(2, 1'b0);
        wait_for("csum_ok_run", 1'b0);
        @(negedge clk);

        // Bad checksum: ERROR with the core held in reset.
        start_load(2, cs);
        src_q = '{16'hFFFF, 16'h0002, 16'h0002};
        applyStimulus(2, 1'b0);
        wait_for("csum_bad_err", 1'b1);
        checkOutput("csum_bad_core_rst", 32'(core_rst), 1);
        checkOutput("csum_bad_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("csum_bad_core_rst_held", 32'(core_rst), 1);
        checkOutput("csum_bad_err_held", 32'(err), 1);
`endif

        // Reset after two of five words.
        start_load(5, cs);
        src_q = '{16'h0E01, 16'h0E02};
        applyStimulus(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_core_rst", 32'(core_rst), 1);
        checkOutput("midrst_in_ready", 32'(in_ready), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("midrst_idle_in_ready", 32'(in_ready), 0);
        checkOutput("midrst_idle_mem_we", 32'(mem_we), 0);

        // Fresh load after the reset, reaching RUN.
        start_load(2, cs);
        done_q.push_back(exp_done(cs, 2));
        src_q = '{16'h0101, 16'h0202};
`ifdef RV16_BOOT_CHECKSUM_EN
        src_q.push_back(16'h0303);
`endif
        applyStimulus(2, 1'b0);
        wait_for("after_rst_run", 1'b0);
        @(negedge clk);

        // Restart from RUN: core_rst rises next cycle, writes restart at 0.
        start_load(3, cs);
        checkOutput("rerun_core_rst", 32'(core_rst), 1);
        checkOutput("rerun_busy", 32'(busy), 1);
        done_q.push_back(exp_done(cs, 3));
        src_q = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
`ifdef RV16_BOOT_CHECKSUM_EN
        src_q.push_back(16'h2121);
`endif
        applyStimulus(3, 1'b0);
        wait_for("rerun_run", 1'b0);
        @(negedge clk);

        checkOutput("sb_writes_left", wr_q.size(), 0);
        checkOutput("sb_done_left", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
